// File: rtl/pointer_axis_pkg.sv
// Shared types, ps2_mouse field positions and arithmetic helpers for the
// pointer_axis_emu analog-axis source selector.
package pointer_axis_pkg;

    typedef enum logic {
        PA_JOY   = 1'b0,
        PA_MOUSE = 1'b1
    } pa_mode_e;

    localparam int JOY_W          = 21;
    localparam int PS2_STROBE_BIT = 24;
    localparam int PS2_DY_LSB     = 16;
    localparam int PS2_DX_LSB     = 8;
    localparam int PS2_YSIGN_BIT  = 5;
    localparam int PS2_XSIGN_BIT  = 4;
    localparam int PS2_BTN_LSB    = 0;
    localparam int JOY_BTN_LO     = 4;
    localparam int JOY_BTN_HI     = 5;

    function automatic int clamp_mag(input int v, input int mag);
        if (v > mag) begin
            return mag;
        end else if (v < -mag) begin
            return -mag;
        end else begin
            return v;
        end
    endfunction

    // Saturate to the signed range of a width-bit value.
    function automatic int saturate(input int v, input int width);
        int hi;
        int lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    function automatic int toward_zero(input int v);
        if (v > 0) begin
            return v - 32'sd1;
        end else if (v < 0) begin
            return v + 32'sd1;
        end else begin
            return v;
        end
    endfunction

    // Sign-extended raw delta, scaled down by shift, then clamped per packet.
    function automatic int mouse_delta(input logic [7:0] raw, input logic sgn,
                                       input int shift, input int dmax);
        logic signed [8:0] v9;
        v9 = $signed({sgn, raw}) >>> shift;
        return clamp_mag(int'(v9), dmax);
    endfunction

endpackage

// File: rtl/pointer_axis_emu_if.sv
// Bus bundle between hps_io-side sources and the core's per-port axis inputs.
interface pointer_axis_emu_if #(
    parameter int AXIS_W    = 8,
    parameter int NUM_PORTS = 2
);
    localparam int MPW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [24:0]                                ps2_mouse;
    logic [NUM_PORTS*16-1:0]                    joya;
    logic [NUM_PORTS*pointer_axis_pkg::JOY_W-1:0] joy;
    logic                                       cpu_halt;
    logic [MPW-1:0]                             mouse_port;
    logic                                       recenter_en;
    logic [NUM_PORTS*AXIS_W-1:0]                axis_x;
    logic [NUM_PORTS*AXIS_W-1:0]                axis_y;
    logic [NUM_PORTS*pointer_axis_pkg::JOY_W-1:0] joy_out;
    logic [NUM_PORTS-1:0]                       mouse_active;

    modport master (
        output ps2_mouse, joya, joy, cpu_halt, mouse_port, recenter_en,
        input  axis_x, axis_y, joy_out, mouse_active
    );

    modport slave (
        input  ps2_mouse, joya, joy, cpu_halt, mouse_port, recenter_en,
        output axis_x, axis_y, joy_out, mouse_active
    );
endinterface

// File: rtl/pointer_axis_chan.sv
// One controller port: JOY/MOUSE mode, saturating mouse accumulators and
// registered outputs. Auto-recentre exists only with POINTER_AXIS_RECENTER_EN.
module pointer_axis_chan
    import pointer_axis_pkg::*;
#(
    parameter int AXIS_W    = 8,
    parameter int DECAY_DIV = 65536
) (
    input  logic                     CLK_VIDEO,
    input  logic                     reset,
    input  logic                     toggle,
    input  logic                     sel,
    input  logic                     cpu_halt,
    input  logic                     recenter_en,
    input  logic signed [AXIS_W:0]   dx,
    input  logic signed [AXIS_W:0]   dy,
    input  logic [15:0]              joya,
    input  logic [JOY_W-1:0]         joy,
    input  logic [1:0]               buttons,
    output logic [AXIS_W-1:0]        axis_x,
    output logic [AXIS_W-1:0]        axis_y,
    output logic [JOY_W-1:0]         joy_out,
    output logic                     mouse_active
);

    pa_mode_e                mode_r;
    logic signed [AXIS_W:0]  acc_x_r;
    logic signed [AXIS_W:0]  acc_y_r;
    logic                    exit_s;
    logic                    decay_s;
    logic [AXIS_W-1:0]       joy_x_s;
    logic [AXIS_W-1:0]       joy_y_s;
    logic [JOY_W-1:0]        joy_mouse_s;

    assign exit_s  = (joya != 16'h0000) || cpu_halt || !sel;
    assign joy_x_s = AXIS_W'($signed(joya[7:0]));
    assign joy_y_s = AXIS_W'($signed(joya[15:8]));

    // Mouse buttons take over the joystick button pair while in MOUSE mode.
    always_comb begin
        joy_mouse_s = joy;
        joy_mouse_s[JOY_BTN_HI:JOY_BTN_LO] = buttons;
    end

`ifdef POINTER_AXIS_RECENTER_EN
    localparam int                PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DECAY_DIV - 1);

    logic [PRE_W-1:0] presc_r;

    assign decay_s = (mode_r == PA_MOUSE) && recenter_en && (presc_r == PRE_LAST);

    // Recentre prescaler, restarted by any packet or by leaving MOUSE.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            presc_r <= '0;
        end else if (exit_s || toggle) begin
            presc_r <= '0;
        end else if ((mode_r == PA_MOUSE) && recenter_en) begin
            presc_r <= decay_s ? '0 : presc_r + PRE_W'(1);
        end else begin
            presc_r <= presc_r;
        end
    end
`else
    logic [31:0] unused_s;

    assign decay_s  = 1'b0;
    assign unused_s = {recenter_en, 31'(DECAY_DIV)};
`endif

    // Mode FSM and accumulators; outputs are driven from the pre-edge mode.
    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            mode_r       <= PA_JOY;
            acc_x_r      <= '0;
            acc_y_r      <= '0;
            axis_x       <= '0;
            axis_y       <= '0;
            joy_out      <= '0;
            mouse_active <= 1'b0;
        end else begin
            case (mode_r)
                PA_MOUSE: begin
                    axis_x       <= acc_x_r[AXIS_W-1:0];
                    axis_y       <= acc_y_r[AXIS_W-1:0];
                    joy_out      <= joy_mouse_s;
                    mouse_active <= 1'b1;
                end
                default: begin
                    axis_x       <= joy_x_s;
                    axis_y       <= joy_y_s;
                    joy_out      <= joy;
                    mouse_active <= 1'b0;
                end
            endcase

            if (exit_s) begin
                mode_r  <= PA_JOY;
                acc_x_r <= '0;
                acc_y_r <= '0;
            end else if (toggle) begin
                mode_r  <= PA_MOUSE;
                acc_x_r <= (AXIS_W+1)'(saturate(int'(acc_x_r) + int'(dx), AXIS_W));
                acc_y_r <= (AXIS_W+1)'(saturate(int'(acc_y_r) + int'(dy), AXIS_W));
            end else if (decay_s) begin
                mode_r  <= mode_r;
                acc_x_r <= (AXIS_W+1)'(toward_zero(int'(acc_x_r)));
                acc_y_r <= (AXIS_W+1)'(toward_zero(int'(acc_y_r)));
            end else begin
                mode_r  <= mode_r;
                acc_x_r <= acc_x_r;
                acc_y_r <= acc_y_r;
            end
        end
    end

endmodule

// File: rtl/pointer_axis_emu.sv
// Analog-axis source selector: shared mouse strobe detect and delta scaling,
// one pointer_axis_chan per port. Optional recentre: POINTER_AXIS_RECENTER_EN.
module pointer_axis_emu
    import pointer_axis_pkg::*;
#(
    parameter int AXIS_W      = 8,
    parameter int NUM_PORTS   = 2,
    parameter int DELTA_MAX   = 10,
    parameter int MOUSE_SHIFT = 1,
    parameter int DECAY_DIV   = 65536
) (
    input  logic               CLK_VIDEO,
    input  logic               reset,
    pointer_axis_emu_if.slave  bus
);

    localparam int MPW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                          strobe_prev_r;
    logic                          toggle_s;
    logic signed [AXIS_W:0]        dx_s;
    logic signed [AXIS_W:0]        dy_s;
    logic [NUM_PORTS*AXIS_W-1:0]   axis_x_s;
    logic [NUM_PORTS*AXIS_W-1:0]   axis_y_s;
    logic [NUM_PORTS*JOY_W-1:0]    joy_out_s;
    logic [NUM_PORTS-1:0]          mouse_active_s;
    logic [3:0]                    unused_s;

    // Previous strobe; also loaded during reset so release never looks like a packet.
    always_ff @(posedge CLK_VIDEO) begin
        strobe_prev_r <= bus.ps2_mouse[PS2_STROBE_BIT];
    end

    assign toggle_s = bus.ps2_mouse[PS2_STROBE_BIT] != strobe_prev_r;
    assign dx_s = (AXIS_W+1)'(mouse_delta(bus.ps2_mouse[PS2_DX_LSB +: 8],
                                          bus.ps2_mouse[PS2_XSIGN_BIT], MOUSE_SHIFT, DELTA_MAX));
    assign dy_s = (AXIS_W+1)'(mouse_delta(bus.ps2_mouse[PS2_DY_LSB +: 8],
                                          bus.ps2_mouse[PS2_YSIGN_BIT], MOUSE_SHIFT, DELTA_MAX));
    assign unused_s = {bus.ps2_mouse[7:6], bus.ps2_mouse[3:2]};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
        pointer_axis_chan #(
            .AXIS_W    (AXIS_W),
            .DECAY_DIV (DECAY_DIV)
        ) u_chan (
            .CLK_VIDEO    (CLK_VIDEO),
            .reset        (reset),
            .toggle       (toggle_s),
            .sel          (bus.mouse_port == MPW'(p)),
            .cpu_halt     (bus.cpu_halt),
            .recenter_en  (bus.recenter_en),
            .dx           (dx_s),
            .dy           (dy_s),
            .joya         (bus.joya[p*16 +: 16]),
            .joy          (bus.joy[p*JOY_W +: JOY_W]),
            .buttons      (bus.ps2_mouse[PS2_BTN_LSB +: 2]),
            .axis_x       (axis_x_s[p*AXIS_W +: AXIS_W]),
            .axis_y       (axis_y_s[p*AXIS_W +: AXIS_W]),
            .joy_out      (joy_out_s[p*JOY_W +: JOY_W]),
            .mouse_active (mouse_active_s[p])
        );
    end

    assign bus.axis_x       = axis_x_s;
    assign bus.axis_y       = axis_y_s;
    assign bus.joy_out      = joy_out_s;
    assign bus.mouse_active = mouse_active_s;

endmodule

// File: tb/tb_pointer_axis_emu.sv
// Directed plus randomized bench for pointer_axis_emu against a per-port
// behavioural model of the mode, accumulator and recentre rules.
module tb_pointer_axis_emu;
    localparam int AXIS_W      = 8;
    localparam int NP          = 2;
    localparam int DELTA_MAX   = 10;
    localparam int MOUSE_SHIFT = 1;
    localparam int DECAY_DIV   = 4;
    localparam int JW          = 21;

    logic CLK_VIDEO = 1'b0;
    logic reset     = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    int   m_mode [NP];
    int   m_ax   [NP];
    int   m_ay   [NP];
    int   m_pre  [NP];
    logic m_prev;

    pointer_axis_emu_if #(.AXIS_W(AXIS_W), .NUM_PORTS(NP)) bus ();

    pointer_axis_emu #(
        .AXIS_W      (AXIS_W),
        .NUM_PORTS   (NP),
        .DELTA_MAX   (DELTA_MAX),
        .MOUSE_SHIFT (MOUSE_SHIFT),
        .DECAY_DIV   (DECAY_DIV)
    ) dut (
        .CLK_VIDEO (CLK_VIDEO),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    function automatic int sat(input int v);
        int hi = (1 << (AXIS_W - 1)) - 1;
        int lo = -(1 << (AXIS_W - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int delta(input logic [7:0] raw, input logic s);
        int r = s ? int'(raw) - 256 : int'(raw);
        r = r >>> MOUSE_SHIFT;
        return (r > DELTA_MAX) ? DELTA_MAX : ((r < -DELTA_MAX) ? -DELTA_MAX : r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pkt(input logic [7:0] dx8, input logic xs, input logic [7:0] dy8,
                       input logic ys, input logic [1:0] btn);
        bus.ps2_mouse = {~bus.ps2_mouse[24], dy8, dx8, 2'b00, ys, xs, 2'b00, btn};
    endtask

    // One clock: predict outputs from the model's pre-edge state, advance it, compare.
    task automatic cycle();
        logic [AXIS_W-1:0] ex [NP];
        logic [AXIS_W-1:0] ey [NP];
        logic [JW-1:0]     ej [NP];
        logic [NP-1:0]     ea;
        logic [15:0]       ja;
        logic [JW-1:0]     jd;
        logic              tog;
        logic              leave;
        int                dx;
        int                dy;
        ea  = '0;
        tog = 1'b0;
        dx  = 0;
        dy  = 0;
        if (!reset) begin
            tog = bus.ps2_mouse[24] != m_prev;
            dx  = delta(bus.ps2_mouse[15:8], bus.ps2_mouse[4]);
            dy  = delta(bus.ps2_mouse[23:16], bus.ps2_mouse[5]);
        end
        m_prev = bus.ps2_mouse[24];
        for (int p = 0; p < NP; p++) begin
            ja = bus.joya[p*16 +: 16];
            jd = bus.joy[p*JW +: JW];
            if (reset) begin
                ex[p] = '0; ey[p] = '0; ej[p] = '0;
                m_mode[p] = 0; m_ax[p] = 0; m_ay[p] = 0; m_pre[p] = 0;
            end else begin
                if (m_mode[p] == 1) begin
                    ex[p] = AXIS_W'(m_ax[p]);
                    ey[p] = AXIS_W'(m_ay[p]);
                    ej[p] = jd;
                    ej[p][5:4] = bus.ps2_mouse[1:0];
                    ea[p] = 1'b1;
                end else begin
                    ex[p] = ja[7:0];
                    ey[p] = ja[15:8];
                    ej[p] = jd;
                end
                leave = (ja != 16'h0000) || bus.cpu_halt || (int'(bus.mouse_port) != p);
                if (leave) begin
                    m_mode[p] = 0; m_ax[p] = 0; m_ay[p] = 0; m_pre[p] = 0;
                end else if (tog) begin
                    m_mode[p] = 1;
                    m_ax[p] = sat(m_ax[p] + dx);
                    m_ay[p] = sat(m_ay[p] + dy);
                    m_pre[p] = 0;
                end
`ifdef POINTER_AXIS_RECENTER_EN
                else if (m_mode[p] == 1 && bus.recenter_en) begin
                    if (m_pre[p] == DECAY_DIV - 1) begin
                        m_pre[p] = 0;
                        m_ax[p] = m_ax[p] - ((m_ax[p] > 0) ? 1 : ((m_ax[p] < 0) ? -1 : 0));
                        m_ay[p] = m_ay[p] - ((m_ay[p] > 0) ? 1 : ((m_ay[p] < 0) ? -1 : 0));
                    end else begin
                        m_pre[p] = m_pre[p] + 1;
                    end
                end
`endif
            end
        end
        @(posedge CLK_VIDEO);
        #1;
        for (int p = 0; p < NP; p++) begin
            check($sformatf("axis_x[%0d]", p), 32'(bus.axis_x[p*AXIS_W +: AXIS_W]), 32'(ex[p]));
            check($sformatf("axis_y[%0d]", p), 32'(bus.axis_y[p*AXIS_W +: AXIS_W]), 32'(ey[p]));
            check($sformatf("joy_out[%0d]", p), 32'(bus.joy_out[p*JW +: JW]), 32'(ej[p]));
        end
        check("mouse_active", 32'(bus.mouse_active), 32'(ea));
    endtask

    initial begin
        logic [7:0] exp_dec;
        bus.ps2_mouse   = 25'h1000000;
        bus.joya        = '0;
        bus.joy         = '0;
        bus.cpu_halt    = 1'b0;
        bus.mouse_port  = 1'b0;
        bus.recenter_en = 1'b0;
        reset           = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (6) cycle();
        check("reset_mouse_active", 32'(bus.mouse_active), 32'h0);
        check("reset_axis_x", 32'(bus.axis_x), 32'h0);
        check("reset_joy_out", 32'(bus.joy_out), 32'h0);

        // First packet: +40 >> 1 = 20, clamped to 10
        pkt(8'h28, 1'b0, 8'h00, 1'b0, 2'b00);
        cycle();
        cycle();
        check("first_pkt_axis_x", 32'(bus.axis_x[7:0]), 32'h0A);
        check("first_pkt_active", 32'(bus.mouse_active), 32'h1);

        // Back-to-back negative packets saturate at -128
        for (int i = 0; i < 20; i++) begin
            pkt(8'h80, 1'b1, 8'h00, 1'b0, 2'b00);
            cycle();
        end
        repeat (3) cycle();
        check("sat_axis_x", 32'(bus.axis_x[7:0]), 32'h80);

        // Stick movement with a simultaneous packet drops the packet and clears acc
        bus.joya[15:0] = 16'h0030;
        pkt(8'h28, 1'b0, 8'h00, 1'b0, 2'b00);
        cycle();
        cycle();
        check("stick_exit_active", 32'(bus.mouse_active[0]), 32'h0);
        check("stick_exit_axis_x", 32'(bus.axis_x[7:0]), 32'h30);
        bus.joya = '0;
        cycle();
        pkt(8'h04, 1'b0, 8'h00, 1'b0, 2'b00);
        cycle();
        cycle();
        check("restart_axis_x", 32'(bus.axis_x[7:0]), 32'h02);
        check("restart_active", 32'(bus.mouse_active), 32'h1);

        // Reroute mouse to port 1; buttons land on port 1 only
        bus.joy = {21'h1000F, 21'h0000F};
        bus.mouse_port = 1'b1;
        pkt(8'h06, 1'b0, 8'h0C, 1'b0, 2'b11);
        cycle();
        cycle();
        check("route_active", 32'(bus.mouse_active), 32'h2);
        check("route_btn_p1", 32'(bus.joy_out[JW+4 +: 2]), 32'h3);
        check("route_btn_p0", 32'(bus.joy_out[5:4]), 32'h0);
        check("route_axis_x1", 32'(bus.axis_x[15:8]), 32'h03);
        check("route_axis_y1", 32'(bus.axis_y[15:8]), 32'h06);

        // Recentre from acc = 3 on port 1
        bus.joya[31:16] = 16'h0001;
        cycle();
        bus.joya = '0;
        bus.ps2_mouse[1:0] = 2'b00;
        bus.recenter_en = 1'b1;
        pkt(8'h06, 1'b0, 8'h00, 1'b0, 2'b00);
        cycle();
        cycle();
        check("decay_start", 32'(bus.axis_x[15:8]), 32'h03);
        repeat (4) cycle();
`ifdef POINTER_AXIS_RECENTER_EN
        exp_dec = 8'h02;
`else
        exp_dec = 8'h03;
`endif
        check("decay_step1", 32'(bus.axis_x[15:8]), 32'(exp_dec));
        repeat (14) cycle();
`ifdef POINTER_AXIS_RECENTER_EN
        exp_dec = 8'h00;
`else
        exp_dec = 8'h03;
`endif
        check("decay_end", 32'(bus.axis_x[15:8]), 32'(exp_dec));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                pkt(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
            end else begin
                bus.ps2_mouse[1:0] = 2'($urandom);
            end
            for (int p = 0; p < NP; p++) begin
                bus.joya[p*16 +: 16] = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0000;
            end
            bus.joy         = 42'({$urandom(), $urandom()});
            bus.cpu_halt    = ($urandom_range(0, 15) == 0);
            bus.recenter_en = 1'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                bus.mouse_port = 1'($urandom);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
